// File: rtl/muldiv_seq_cu.sv
// RV32M sequential multiply/divide control-and-execute unit.
// Decodes M-type instructions, runs a one-bit-per-cycle shift-add multiplier
// or restoring divider on operand magnitudes, applies sign fix-up in a final
// cycle and returns a registered result with a one-cycle done pulse.
module muldiv_seq_cu #(
  parameter int unsigned XLEN      = 32,
  parameter bit          EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  input  logic            flush_i,
  input  logic [6:0]      opcode_i,
  input  logic [2:0]      func3_i,
  input  logic [6:0]      func7_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            is_m_o,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned     CW      = $clog2(XLEN + 1);
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]     cnt;
  logic [2:0]        f3_q;
  logic              a_neg_q, b_neg_q, dz_q, ovf_q;
  logic [XLEN-1:0]   rs1_q;
  logic [XLEN-1:0]   opb_q;
  // Shared iteration register: {product hi, multiplier/product lo} for
  // multiply, {partial remainder, dividend/quotient} for divide.
  logic [2*XLEN-1:0] acc_q;

  logic              accept;
  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              dz_in, ovf_in, special_in;
  logic [XLEN-1:0]   spec_res;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift, div_trial;
  logic              div_ge;
  logic [2*XLEN-1:0] div_next;

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s;
  logic [XLEN-1:0]   fix_res;

  assign is_m_o  = (opcode_i == 7'b0110011) && (func7_i == 7'b0000001);
  assign accept  = (state == S_IDLE) && valid_i && is_m_o && !flush_i;
  assign stall_o = valid_i && is_m_o && !flush_i && (state != S_DONE);
  assign busy_o  = (state != S_IDLE);
  assign done_o  = (state == S_DONE);

  // Operand sign/magnitude decode and special-case detection for the accept cycle
  always_comb begin
    a_signed   = (func3_i == 3'b001) || (func3_i == 3'b010) ||
                 (func3_i == 3'b100) || (func3_i == 3'b110);
    b_signed   = (func3_i == 3'b001) || (func3_i == 3'b100) || (func3_i == 3'b110);
    a_neg      = a_signed && rs1_i[XLEN-1];
    b_neg      = b_signed && rs2_i[XLEN-1];
    a_mag      = a_neg ? ('0 - rs1_i) : rs1_i;
    b_mag      = b_neg ? ('0 - rs2_i) : rs2_i;
    dz_in      = func3_i[2] && (rs2_i == '0);
    ovf_in     = func3_i[2] && !func3_i[0] && (rs1_i == MIN_NEG) && (rs2_i == '1);
    special_in = dz_in || ovf_in;
    spec_res   = '0;
    if (dz_in) spec_res = func3_i[1] ? rs1_i : '1;
    else       spec_res = func3_i[1] ? '0 : MIN_NEG;
  end

  // One iteration step of the unsigned multiply and restoring divide cores
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = acc_q[2*XLEN-1:XLEN-1];
    div_trial = div_shift - {1'b0, opb_q};
    div_ge    = !div_trial[XLEN];
    div_next  = {(div_ge ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0]),
                 acc_q[XLEN-2:0], div_ge};
  end

  // Sign fix-up, special-case override and result selection for the FIX cycle
  always_comb begin
    prod_s  = (a_neg_q ^ b_neg_q) ? ('0 - acc_q) : acc_q;
    quo_s   = (a_neg_q ^ b_neg_q) ? ('0 - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
    rem_s   = a_neg_q ? ('0 - acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
    fix_res = '0;
    case (f3_q)
      3'b000:                 fix_res = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101: begin
        if (dz_q)       fix_res = '1;
        else if (ovf_q) fix_res = MIN_NEG;
        else            fix_res = quo_s;
      end
      default: begin
        if (dz_q)       fix_res = rs1_q;
        else if (ovf_q) fix_res = '0;
        else            fix_res = rem_s;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; flush returns to IDLE from any state
  always_comb begin
    state_nxt = state;
    if (flush_i) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (accept) state_nxt = (EARLY_OUT && special_in) ? S_DONE : S_BUSY;
        S_BUSY: if (cnt == LAST) state_nxt = S_FIX;
        S_FIX:  state_nxt = S_DONE;
        S_DONE: state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Operand latch, iteration datapath, counter and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      f3_q     <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      rs1_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      result_o <= '0;
    end else if (flush_i) begin
      cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cnt     <= '0;
            f3_q    <= func3_i;
            a_neg_q <= a_neg;
            b_neg_q <= b_neg;
            dz_q    <= dz_in;
            ovf_q   <= ovf_in;
            rs1_q   <= rs1_i;
            opb_q   <= b_mag;
            // Multiply and divide both start from {0, |rs1|}.
            acc_q   <= {{XLEN{1'b0}}, a_mag};
            if (EARLY_OUT && special_in) result_o <= spec_res;
          end
        end
        S_BUSY: begin
          acc_q <= f3_q[2] ? div_next : mul_next;
          cnt   <= cnt + 1'b1;
        end
        S_FIX: begin
          result_o <= fix_res;
          cnt      <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
